vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//   Source end of the VGA pixel path: generates horizontal/vertical timing, hsync/vsync,
//   the vidon (video-on) qualifier and the pixel coordinate/linear address used to fetch
//   the 8-bit RRRGGGBB pixel from frame memory. The downstream colour stage consumes vidon.
//   Default timing is 640x480@60 Hz from a 50 MHz clk with a divide-by-2 pixel enable.
// PARAMETERS
//   CLK_DIV    2    clk cycles per pixel (>=1); pix_en pulses once every CLK_DIV clks
//   H_VISIBLE  640  visible pixels per line
//   H_FP       16   horizontal front porch (pixels)
//   H_SYNC     96   horizontal sync width (pixels)
//   H_BP       48   horizontal back porch (pixels)
//   V_VISIBLE  480  visible lines per frame
//   V_FP       10   vertical front porch (lines)
//   V_SYNC     2    vertical sync width (lines)
//   V_BP       33   vertical back porch (lines)
//   SYNC_POL   0    active level of hsync/vsync (0 = active-low)
// PORTS
//   clk          in   1   system clock; all state changes on posedge
//   rst          in   1   synchronous, active-high reset
//   pix_en       out  1   one-clk pulse marking the last clk of the current pixel
//   hc           out  10  horizontal counter, 0..H_TOTAL-1
//   vc           out  10  vertical counter, 0..V_TOTAL-1
//   hsync        out  1   horizontal sync, level SYNC_POL while asserted
//   vsync        out  1   vertical sync, level SYNC_POL while asserted
//   vidon        out  1   1 while (hc,vc) is inside the visible window
//   pix_addr     out  19  linear pixel index vc*H_VISIBLE+hc of the current visible pixel
//   frame_start  out  1   one-clk pulse when counters wrap to (0,0)
// BEHAVIOUR
//   H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_VISIBLE+V_FP+V_SYNC+V_BP (525).
//   Reset (rst=1 at posedge): div=0, hc=0, vc=0, pix_addr=0, active=0, frame_start=0;
//     outputs while active=0: vidon=0, pix_en=0, hsync=vsync=~SYNC_POL.
//   active: set on first posedge with rst=0; remains 1 until next rst.
//   Divider: div counts 0..CLK_DIV-1 and wraps; pix_en = active & (div==CLK_DIV-1).
//     CLK_DIV=1 -> pix_en constantly 1 while active.
//   On pix_en: hc<=hc+1; at hc==H_TOTAL-1, hc<=0 and vc<=vc+1;
//     at (hc,vc)==(H_TOTAL-1,V_TOTAL-1), both wrap to 0. Counters hold otherwise.
//   hsync/vsync/vidon: combinational decodes of registered hc/vc (zero latency vs counters):
//     hsync active iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC;
//     vsync active iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC;
//     vidon = active & (hc<H_VISIBLE) & (vc<V_VISIBLE).
//   pix_addr: incremental, no multiplier. On pix_en with vidon=1, pix_addr<=pix_addr+1;
//     on pix_en at the frame wrap, pix_addr<=0 (wrap has priority). Holds in blanking,
//     so during vidon it always equals vc*H_VISIBLE+hc.
//   frame_start: registered; 1 for exactly the clk after the posedge where the frame wraps.
//   rst mid-frame: all state returns to reset values on that edge; the next frame starts
//     cleanly at (0,0) with no partial sync pulse beyond the reset edge.
//   Downstream stage registers RGB one clk after vidon; the fetch path aligns to that.
// TESTING
//   1 rst held 5 clks, release -> vidon=0, hsync=vsync=1 during rst; vidon=1, hc=vc=0 next clk.
//   2 Defaults, run 1 line -> line period 1600 clks; hsync low exactly 192 clks starting
//     at hc=656; vidon high for 1280 clks (640 pix_en) per visible line.
//   3 Full frame -> frame_start period 840000 clks; vsync low for 2 lines (3200 clks) at vc=490.
//   4 pix_addr check -> at (hc=639,vc=479) pix_addr=307199; at (0,1) = 640; after wrap = 0.
//   5 rst asserted at (hc=300,vc=200) -> next clk hc=vc=pix_addr=0, frame_start=0, sync idle.
//   6 CLK_DIV=1, SYNC_POL=1 -> pix_en always 1; hsync high 96 clks; line period 800 clks.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA horizontal/vertical timing, sync, video-on and linear pixel address generator
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [9:0]  hc,
  output logic [9:0]  vc,
  output logic        hsync,
  output logic        vsync,
  output logic        vidon,
  output logic [18:0] pix_addr,
  output logic        frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic SP = 1'(SYNC_POL);
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    hc_q, hc_d, vc_q, vc_d;
  logic [18:0]   pix_addr_q, pix_addr_d;
  logic          active_q, active_d, frame_start_q, frame_start_d;
  logic          h_end, v_end, hs_on, vs_on;
  always_comb begin
    pix_en = active_q & (div_q == DIV_LAST);
    h_end = hc_q == 10'(H_TOTAL - 1);
    v_end = vc_q == 10'(V_TOTAL - 1);
    hs_on = (hc_q >= 10'(H_VISIBLE + H_FP)) & (hc_q < 10'(H_VISIBLE + H_FP + H_SYNC));
    vs_on = (vc_q >= 10'(V_VISIBLE + V_FP)) & (vc_q < 10'(V_VISIBLE + V_FP + V_SYNC));
    vidon = active_q & (hc_q < 10'(H_VISIBLE)) & (vc_q < 10'(V_VISIBLE));
    hsync = (active_q & hs_on) ? SP : ~SP;
    vsync = (active_q & vs_on) ? SP : ~SP;
    active_d = 1'b1;
    // divider only runs once active so the first pixel gets its full CLK_DIV clks
    div_d = (!active_q || div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    hc_d = pix_en ? (h_end ? '0 : hc_q + 10'd1) : hc_q;
    vc_d = (pix_en & h_end) ? (v_end ? '0 : vc_q + 10'd1) : vc_q;
    pix_addr_d = !pix_en ? pix_addr_q : (h_end & v_end) ? '0 : vidon ? pix_addr_q + 19'd1 : pix_addr_q;
    frame_start_d = pix_en & h_end & v_end;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      pix_addr_q    <= '0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      pix_addr_q    <= pix_addr_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign pix_addr    = pix_addr_q;
  assign frame_start = frame_start_q;
endmodule
